// File: rtl/util_trafic_pkg.sv
// Shared definitions for the traffic checker/generator utilities: FSM states,
// backpressure LFSR constants and saturating-counter helpers.
package util_trafic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2
  } chk_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam logic [31:0] SAT32_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic inc);
    return (inc && (v != SAT32_MAX)) ? v + 32'd1 : v;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {^(v & LFSR_TAPS), v[15:1]};
  endfunction

endpackage

// File: rtl/util_trafic_rate_meter.sv
// Beats-per-window meter: free-running window counter, saturating accumulator
// and a latched result that updates once per completed window.
module util_trafic_rate_meter
  import util_trafic_pkg::*;
#(
  parameter int unsigned WINDOW = 150_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic        clr,
  input  logic        beat,
  output logic [31:0] rate_cnt
);

  localparam int unsigned          WIN_W    = $clog2(WINDOW);
  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW - 1);

  logic [WIN_W-1:0] win_q, win_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      rate_q, rate_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    win_d  = win_q;
    acc_d  = acc_q;
    rate_d = rate_q;
    if (clr) begin
      win_d  = '0;
      acc_d  = '0;
      rate_d = '0;
    end else if (!en) begin
      win_d = '0;
      acc_d = '0;
    end else if (win_q == WIN_LAST) begin
      // A beat landing on the last cycle belongs to the window that closes now.
      rate_d = sat_inc32(acc_q, beat);
      acc_d  = '0;
      win_d  = '0;
    end else begin
      acc_d = sat_inc32(acc_q, beat);
      win_d = win_q + WIN_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops sample together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_q  <= '0;
      acc_q  <= '0;
      rate_q <= '0;
    end else begin
      win_q  <= win_d;
      acc_q  <= acc_d;
      rate_q <= rate_d;
    end
  end

  assign rate_cnt = rate_q;

endmodule

// File: rtl/util_trafic_checker.sv
// AXI-Stream sink checking an incrementing-counter stream; reports lock, errors and rate.
// Define UTIL_TRAFIC_CHECKER_BP_EN to throttle tready with a free-running 16-bit LFSR.
module util_trafic_checker
  import util_trafic_pkg::*;
#(
  parameter int unsigned TBYTE_NUM  = 16,
  parameter int unsigned ID_WIDTH   = 5,
  parameter int unsigned DEST_WIDTH = 5,
  parameter int unsigned WINDOW     = 150_000_000,
  parameter int unsigned LOCK_NUM   = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [TBYTE_NUM*8-1:0]  s_axis_tdata,
  input  logic [TBYTE_NUM-1:0]    s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic [ID_WIDTH-1:0]     s_axis_tid,
  input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
  output logic                    locked,
  output logic                    err_pulse,
  output logic [63:0]             beat_cnt,
  output logic [31:0]             err_cnt,
  output logic [TBYTE_NUM*8-1:0]  first_err_data,
  output logic [31:0]             rate_cnt
);

  localparam int unsigned      DW       = TBYTE_NUM * 8;
  localparam int unsigned      RUN_W    = $clog2(LOCK_NUM + 1);
  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_NUM);

  chk_state_e       state_q, state_d;
  logic             tready_q, tready_d;
  logic [DW-1:0]    exp_q, exp_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [63:0]      beat_cnt_q, beat_cnt_d;
  logic [31:0]      err_cnt_q, err_cnt_d;
  logic [DW-1:0]    first_err_q, first_err_d;

  logic hs;
  logic beat_good;
  logic unused_inputs;

  assign hs            = s_axis_tvalid & tready_q;
  assign beat_good     = (s_axis_tdata == exp_q) && (&s_axis_tkeep);
  assign unused_inputs = ^{s_axis_tlast, s_axis_tid, s_axis_tdest};

`ifdef UTIL_TRAFIC_CHECKER_BP_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d   = lfsr_next(lfsr_q);
  assign tready_d = (state_d != ST_IDLE) & lfsr_d[0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end
`else
  // state_d is IDLE whenever en is low, so this already carries the en term.
  assign tready_d = (state_d != ST_IDLE);
`endif

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    run_d       = run_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    beat_cnt_d  = beat_cnt_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;

    if (clr) begin
      // A beat handshaken alongside clr is consumed but neither counted nor checked.
      state_d     = en ? ST_SYNC : ST_IDLE;
      run_d       = '0;
      locked_d    = 1'b0;
      beat_cnt_d  = '0;
      err_cnt_d   = '0;
      first_err_d = '0;
    end else if (!en) begin
      state_d  = ST_IDLE;
      run_d    = '0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_SYNC;
        ST_SYNC: begin
          if (hs) begin
            exp_d      = s_axis_tdata + DW'(1);
            beat_cnt_d = beat_cnt_q + 64'd1;
            run_d      = RUN_W'(1);
            locked_d   = (run_d == RUN_LOCK);
            state_d    = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (hs) begin
            beat_cnt_d = beat_cnt_q + 64'd1;
            if (beat_good) begin
              exp_d    = exp_q + DW'(1);
              if (run_q != RUN_LOCK) run_d = run_q + RUN_W'(1);
              locked_d = (run_d == RUN_LOCK);
            end else begin
              // Resync on the bad beat so a single drop costs exactly one error.
              err_pulse_d = 1'b1;
              err_cnt_d   = sat_inc32(err_cnt_q, 1'b1);
              if (err_cnt_q == '0) first_err_d = s_axis_tdata;
              exp_d       = s_axis_tdata + DW'(1);
              run_d       = '0;
              locked_d    = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      tready_q    <= 1'b0;
      exp_q       <= '0;
      run_q       <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      beat_cnt_q  <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      tready_q    <= tready_d;
      exp_q       <= exp_d;
      run_q       <= run_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      beat_cnt_q  <= beat_cnt_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  util_trafic_rate_meter #(
    .WINDOW (WINDOW)
  ) u_rate (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .clr      (clr),
    .beat     (hs),
    .rate_cnt (rate_cnt)
  );

  assign s_axis_tready  = tready_q;
  assign locked         = locked_q;
  assign err_pulse      = err_pulse_q;
  assign beat_cnt       = beat_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_data = first_err_q;

endmodule

// File: tb/tb_util_trafic_checker.sv
// Self-checking bench for util_trafic_checker: randomized counter streams scored
// against a beat-level reference model, plus rate, clear, reset and wrap scenarios.
module tb_util_trafic_checker;

  localparam int unsigned TBYTE_NUM = 16;
  localparam int unsigned DW        = TBYTE_NUM * 8;
  localparam int unsigned WINDOW    = 10;
  localparam int unsigned LOCK_NUM  = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic                 en, clr, tvalid, tlast;
  logic [DW-1:0]        tdata;
  logic [TBYTE_NUM-1:0] tkeep;
  logic [4:0]           tid, tdest;
  logic                 tready, locked, err_pulse;
  logic [63:0]          beat_cnt;
  logic [31:0]          err_cnt, rate_cnt;
  logic [DW-1:0]        first_err_data;

  logic        en8, clr8, valid8;
  logic [7:0]  data8;
  logic [0:0]  keep8;
  logic        tready8, locked8, err_pulse8;
  logic [63:0] beat_cnt8;
  logic [31:0] err_cnt8, rate_cnt8;
  logic [7:0]  first_err8;

  util_trafic_checker #(
    .TBYTE_NUM(TBYTE_NUM), .ID_WIDTH(5), .DEST_WIDTH(5), .WINDOW(WINDOW), .LOCK_NUM(LOCK_NUM)
  ) u_dut (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tdata(tdata), .s_axis_tkeep(tkeep),
    .s_axis_tlast(tlast), .s_axis_tid(tid), .s_axis_tdest(tdest),
    .locked(locked), .err_pulse(err_pulse), .beat_cnt(beat_cnt), .err_cnt(err_cnt),
    .first_err_data(first_err_data), .rate_cnt(rate_cnt)
  );

  util_trafic_checker #(
    .TBYTE_NUM(1), .ID_WIDTH(5), .DEST_WIDTH(5), .WINDOW(4), .LOCK_NUM(2)
  ) u_dut8 (
    .clk(clk), .rstn(rstn), .en(en8), .clr(clr8),
    .s_axis_tvalid(valid8), .s_axis_tready(tready8), .s_axis_tdata(data8), .s_axis_tkeep(keep8),
    .s_axis_tlast(tlast), .s_axis_tid(tid), .s_axis_tdest(tdest),
    .locked(locked8), .err_pulse(err_pulse8), .beat_cnt(beat_cnt8), .err_cnt(err_cnt8),
    .first_err_data(first_err8), .rate_cnt(rate_cnt8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the checker should conclude about the beats sent so far.
  bit                m_synced;
  logic [DW-1:0]     m_exp;
  longint unsigned   m_beats;
  int unsigned       m_errs;
  logic [DW-1:0]     m_first;
  int                m_run;

  function automatic logic [DW-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_clear();
    m_synced = 1'b0; m_beats = 0; m_errs = 0; m_first = '0; m_run = 0;
  endtask

  task automatic clear_dut();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_clear();
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [TBYTE_NUM-1:0] k,
                           input int gap, output bit bad);
    bit hs;
    bad = 1'b0;
    hs  = 1'b0;
    tvalid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    tdata = d; tkeep = k; tvalid = 1'b1;
    for (int c = 0; c < 200 && !hs; c++) begin
      @(negedge clk); hs = tready;
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    if (!hs) begin
      n_checks++; n_fail++;
      $display("FAIL handshake_timeout: tready stayed low, want a handshake within 200 cycles");
      return;
    end
    if (!m_synced) begin
      m_synced = 1'b1; m_run = 1;
    end else if (d == m_exp && k == {TBYTE_NUM{1'b1}}) begin
      m_run++;
    end else begin
      bad = 1'b1;
      if (m_errs == 0) m_first = d;
      if (m_errs != 32'hFFFF_FFFF) m_errs++;
      m_run = 0;
    end
    m_exp = d + DW'(1);
    m_beats++;
  endtask

  task automatic send_beat8(input logic [7:0] d);
    bit hs;
    hs = 1'b0;
    data8 = d; keep8 = 1'b1; valid8 = 1'b1;
    for (int c = 0; c < 200 && !hs; c++) begin
      @(negedge clk); hs = tready8;
      @(posedge clk); #1;
    end
    valid8 = 1'b0;
    if (!hs) begin
      n_checks++; n_fail++;
      $display("FAIL handshake8_timeout: tready stayed low, want a handshake within 200 cycles");
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({tready, locked, err_pulse, beat_cnt, err_cnt, rate_cnt, first_err_data} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero stats/tready, want all zero");
    end
    n_checks++;
    if ({tready8, locked8, err_pulse8, beat_cnt8, err_cnt8, first_err8} !== '0) begin
      n_fail++; $display("FAIL reset_outputs8: got nonzero stats/tready, want all zero");
    end
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (tready !== 1'b0) begin n_fail++; $display("FAIL ready_while_disabled: got %0b want 0", tready); end
    en = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (tready !== 1'b1) begin n_fail++; $display("FAIL ready_after_en: got %0b want 1", tready); end
    model_clear();
  endtask

  task automatic test_stream();
    bit bad;
    for (int i = 0; i < 100; i++) begin
      send_beat(DW'(i), '1, 0, bad);
      n_checks++;
      if (locked !== (m_run >= LOCK_NUM)) begin
        n_fail++; $display("FAIL stream_locked beat %0d: got %0b want %0b", i, locked, m_run >= LOCK_NUM);
      end
      n_checks++;
      if (err_pulse !== bad) begin n_fail++; $display("FAIL stream_err_pulse beat %0d: got %0b want %0b", i, err_pulse, bad); end
    end
    n_checks++;
    if (beat_cnt !== 64'd100) begin n_fail++; $display("FAIL stream_beat_cnt: got %0d want 100", beat_cnt); end
    n_checks++;
    if (err_cnt !== 32'd0) begin n_fail++; $display("FAIL stream_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_skip();
    bit bad;
    int pulses;
    pulses = 0;
    clear_dut();
    n_checks++;
    if ({locked, beat_cnt, err_cnt} !== '0) begin n_fail++; $display("FAIL skip_after_clr: got nonzero stats, want zero"); end
    for (int v = 0; v <= 80; v++) begin
      if (v == 50) continue;
      send_beat(DW'(v), '1, 0, bad);
      if (err_pulse === 1'b1) pulses++;
      n_checks++;
      if (err_pulse !== bad) begin n_fail++; $display("FAIL skip_err_pulse value %0d: got %0b want %0b", v, err_pulse, bad); end
      n_checks++;
      if (locked !== (m_run >= LOCK_NUM)) begin
        n_fail++; $display("FAIL skip_locked value %0d: got %0b want %0b", v, locked, m_run >= LOCK_NUM);
      end
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL skip_pulse_count: got %0d want 1", pulses); end
    n_checks++;
    if (err_cnt !== 32'd1) begin n_fail++; $display("FAIL skip_err_cnt: got %0d want 1", err_cnt); end
    n_checks++;
    if (first_err_data !== DW'(51)) begin n_fail++; $display("FAIL skip_first_err: got %0h want 33", first_err_data); end
  endtask

  task automatic test_en_low();
    bit bad;
    longint unsigned held;
    held = m_beats;
    en = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (tready !== 1'b0) begin n_fail++; $display("FAIL en_low_tready: got %0b want 0", tready); end
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL en_low_locked: got %0b want 0", locked); end
    m_synced = 1'b0; m_run = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (beat_cnt !== held) begin n_fail++; $display("FAIL en_low_hold: got %0d want %0d", beat_cnt, held); end
    en = 1'b1;
    send_beat(rand_data(), '1, 0, bad);
    n_checks++;
    if (err_pulse !== bad) begin n_fail++; $display("FAIL en_reseed_err: got %0b want %0b", err_pulse, bad); end
  endtask

  task automatic test_random();
    bit bad;
    logic [DW-1:0]        d;
    logic [TBYTE_NUM-1:0] k;
    logic [TBYTE_NUM-1:0] one;
    int r;
    one = 1;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 15));
      if (!m_synced || r == 0) d = rand_data();
      else if (r == 1)         d = m_exp + DW'(2);
      else if (r == 3)         d = '1;
      else                     d = m_exp;
      k = (r == 2) ? ~(one << $urandom_range(0, TBYTE_NUM - 1)) : '1;
      send_beat(d, k, int'($urandom_range(0, 2)), bad);
      n_checks++;
      if (err_pulse !== bad) begin n_fail++; $display("FAIL random_err_pulse beat %0d: got %0b want %0b", i, err_pulse, bad); end
      n_checks++;
      if (locked !== (m_run >= LOCK_NUM)) begin
        n_fail++; $display("FAIL random_locked beat %0d: got %0b want %0b", i, locked, m_run >= LOCK_NUM);
      end
    end
    n_checks++;
    if (beat_cnt !== m_beats) begin n_fail++; $display("FAIL random_beat_cnt: got %0d want %0d", beat_cnt, m_beats); end
    n_checks++;
    if (err_cnt !== m_errs) begin n_fail++; $display("FAIL random_err_cnt: got %0d want %0d", err_cnt, m_errs); end
    n_checks++;
    if (first_err_data !== m_first) begin n_fail++; $display("FAIL random_first_err: got %0h want %0h", first_err_data, m_first); end
  endtask

  task automatic test_clr_handshake();
    bit bad;
    bit hs;
    clear_dut();
    for (int v = 0; v < 45; v++) begin
      if (v >= 20 && v < 25) continue;
      send_beat(DW'(v), '1, 0, bad);
    end
    n_checks++;
    if (beat_cnt !== 64'd40 || err_cnt !== 32'd1) begin
      n_fail++; $display("FAIL clr_pre_stats: got beats %0d errs %0d want 40 1", beat_cnt, err_cnt);
    end
    hs = 1'b0;
    tdata = DW'(45); tkeep = '1; tvalid = 1'b1;
    for (int c = 0; c < 200 && !hs; c++) begin
      @(negedge clk); hs = tready; if (hs) clr = 1'b1;
      @(posedge clk); #1;
    end
    clr = 1'b0; tvalid = 1'b0;
    model_clear();
    n_checks++;
    if (!hs) begin n_fail++; $display("FAIL clr_hs_timeout: tready stayed low, want a handshake"); end
    n_checks++;
    if ({locked, err_pulse, beat_cnt, err_cnt, rate_cnt, first_err_data} !== '0) begin
      n_fail++; $display("FAIL clr_stats: got beats %0d errs %0d locked %0b, want all zero", beat_cnt, err_cnt, locked);
    end
    send_beat({4{32'h5A5A_1234}}, '1, 0, bad);
    n_checks++;
    if (err_pulse !== 1'b0 || err_cnt !== 32'd0 || beat_cnt !== 64'd1) begin
      n_fail++; $display("FAIL clr_reseed: got pulse %0b errs %0d beats %0d want 0 0 1", err_pulse, err_cnt, beat_cnt);
    end
  endtask

  task automatic test_rate();
    bit bad;
    tvalid = 1'b0;
    clear_dut();
    for (int i = 0; i < 25; i++) begin
      send_beat(DW'(i), '1, 0, bad);
      if (i == 8) begin
        n_checks++;
        if (rate_cnt !== 32'd0) begin n_fail++; $display("FAIL rate_before_window: got %0d want 0", rate_cnt); end
      end
      if (i == 9) begin
        n_checks++;
        if (rate_cnt !== 32'd10) begin n_fail++; $display("FAIL rate_first_window: got %0d want 10", rate_cnt); end
      end
    end
    n_checks++;
    if (rate_cnt !== 32'd10) begin n_fail++; $display("FAIL rate_full: got %0d want 10", rate_cnt); end
    for (int i = 25; i < 55; i++) send_beat(DW'(i), '1, 1, bad);
    n_checks++;
    if (rate_cnt !== 32'd5) begin n_fail++; $display("FAIL rate_half: got %0d want 5", rate_cnt); end
    en = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    n_checks++;
    if (rate_cnt !== 32'd5) begin n_fail++; $display("FAIL rate_hold_en_low: got %0d want 5", rate_cnt); end
    en = 1'b1;
    m_synced = 1'b0; m_run = 0;
  endtask

  task automatic test_reset_mid();
    bit bad;
    send_beat(DW'(700), '1, 0, bad);
    send_beat(DW'(701), '1, 0, bad);
    send_beat(DW'(900), '1, 0, bad);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    n_checks++;
    if ({tready, locked, err_pulse, beat_cnt, err_cnt, rate_cnt, first_err_data} !== '0) begin
      n_fail++; $display("FAIL reset_mid_async: got beats %0d errs %0d tready %0b, want all zero", beat_cnt, err_cnt, tready);
    end
    repeat (3) @(posedge clk);
    #4 rstn = 1'b1;
    model_clear();
    send_beat(DW'(16'h1234), '1, 0, bad);
    n_checks++;
    if (err_pulse !== bad || err_cnt !== 32'd0 || beat_cnt !== 64'd1) begin
      n_fail++; $display("FAIL reset_mid_reseed: got pulse %0b errs %0d beats %0d want 0 0 1", err_pulse, err_cnt, beat_cnt);
    end
    send_beat(DW'(16'h1235), '1, 0, bad);
    n_checks++;
    if (err_pulse !== bad || beat_cnt !== m_beats) begin
      n_fail++; $display("FAIL reset_mid_next: got pulse %0b beats %0d want %0b %0d", err_pulse, beat_cnt, bad, m_beats);
    end
  endtask

  task automatic test_wrap();
    en8 = 1'b1;
    @(posedge clk); #1;
    send_beat8(8'hFE);
    send_beat8(8'hFF);
    send_beat8(8'h00);
    send_beat8(8'h01);
    n_checks++;
    if (err_cnt8 !== 32'd0) begin n_fail++; $display("FAIL wrap_err_cnt: got %0d want 0", err_cnt8); end
    n_checks++;
    if (beat_cnt8 !== 64'd4) begin n_fail++; $display("FAIL wrap_beat_cnt: got %0d want 4", beat_cnt8); end
    n_checks++;
    if (locked8 !== 1'b1) begin n_fail++; $display("FAIL wrap_locked: got %0b want 1", locked8); end
    send_beat8(8'h03);
    n_checks++;
    if (err_pulse8 !== 1'b1 || err_cnt8 !== 32'd1) begin
      n_fail++; $display("FAIL wrap_bad_beat: got pulse %0b errs %0d want 1 1", err_pulse8, err_cnt8);
    end
    n_checks++;
    if (first_err8 !== 8'h03 || locked8 !== 1'b0) begin
      n_fail++; $display("FAIL wrap_first_err: got %0h locked %0b want 03 0", first_err8, locked8);
    end
  endtask

  initial begin
    en = 1'b0; clr = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    tdata = '0; tkeep = '1; tid = '0; tdest = '0;
    en8 = 1'b0; clr8 = 1'b0; valid8 = 1'b0; data8 = '0; keep8 = 1'b1;
    model_clear();
    m_exp = '0;
    test_reset();
    test_stream();
    test_skip();
    test_en_low();
    test_random();
    test_clr_handshake();
    test_rate();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
